// File: rtl/param_sync_ram_pkg.sv
// Shared types and constants for the parametrised synchronous RAM.
package ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage : ram_pkg

// File: rtl/param_sync_ram_if.sv
// Command / read-response bus between a RAM client and param_sync_ram.
interface param_sync_ram_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
);

    logic              mem_en;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              addr_err;

    modport master (
        output mem_en, rd_wr, addr, wr_data, rd_ready,
        input  cmd_ready, rd_data, rd_valid, busy, addr_err
    );

    modport slave (
        input  mem_en, rd_wr, addr, wr_data, rd_ready,
        output cmd_ready, rd_data, rd_valid, busy, addr_err
    );

endinterface : param_sync_ram_if

// File: rtl/param_sync_ram_core.sv
// Plain storage array with one synchronous write port and one registered read port.
module sync_ram_core #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are never reset; the owner clears them with an init sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : sync_ram_core

// File: rtl/param_sync_ram.sv
// Clocked single-port RAM with post-reset init sweep, backpressured read response
// and out-of-range address flagging.
module param_sync_ram
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 4,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    param_sync_ram_if.slave     bus
);

    localparam int unsigned AW1 = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              busy_q, busy_d;
    logic              rd_oor_q, rd_oor_d;

    logic              cmd_ready_c;
    logic              oor_c;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] core_rdata;

    assign oor_c = ({1'b0, bus.addr} >= AW1'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b1;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            busy_q     <= busy_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        rd_valid_d  = rd_valid_q;
        addr_err_d  = 1'b0;
        busy_d      = busy_q;
        rd_oor_d    = rd_oor_q;
        cmd_ready_c = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = init_ptr_q;
        mem_wdata   = INIT_VAL;

        case (state_q)
            ST_INIT: begin
                mem_we     = !rst;
                init_ptr_d = ADDR_W'(init_ptr_q + 1'b1);
                if (init_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    init_ptr_d = '0;
                    busy_d     = 1'b0;
                end
            end
            ST_RUN: begin
                busy_d      = 1'b0;
                cmd_ready_c = !rd_valid_q || bus.rd_ready;
                if (rd_valid_q && bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                end
                if (bus.mem_en && cmd_ready_c && !rst) begin
                    addr_err_d = oor_c;
                    if (bus.rd_wr == OP_RD) begin
                        // Out-of-range reads answer INIT_VAL without touching the array.
                        rd_valid_d = 1'b1;
                        rd_oor_d   = oor_c;
                        mem_re     = !oor_c;
                    end else begin
                        mem_we    = !oor_c;
                        mem_waddr = bus.addr;
                        mem_wdata = bus.wr_data;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    sync_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (bus.addr),
        .rdata (core_rdata)
    );

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rd_data   = rd_oor_q ? INIT_VAL : core_rdata;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.addr_err  = addr_err_q;

endmodule : param_sync_ram

// File: tb/tb_param_sync_ram.sv
// Directed bench for param_sync_ram: a DEPTH=4 instance and a DEPTH=5 instance.
module tb_param_sync_ram;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    param_sync_ram_if #(.DATA_W(4), .ADDR_W(2)) bus_a ();
    param_sync_ram_if #(.DATA_W(4), .ADDR_W(3)) bus_b ();

    param_sync_ram #(.DATA_W(4), .DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    param_sync_ram #(.DATA_W(4), .DEPTH(5)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [3:0] wvals [4];
    logic [1:0] rseq  [4];
    logic [3:0] rexp  [4];

    initial begin
        wvals = '{4'b0001, 4'b0110, 4'b1110, 4'b1111};
        rseq  = '{2'd3, 2'd0, 2'd1, 2'd2};
        rexp  = '{4'b1111, 4'b0001, 4'b0110, 4'b1110};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.mem_en = 1'b0; bus_a.rd_wr = 1'b0; bus_a.addr = '0;
        bus_a.wr_data = '0;  bus_a.rd_ready = 1'b1;
        bus_b.mem_en = 1'b0; bus_b.rd_wr = 1'b0; bus_b.addr = '0;
        bus_b.wr_data = '0;  bus_b.rd_ready = 1'b1;

        // 1: reset, init sweep, fresh contents read as zero
        tick();
        chk1("rst_busy", bus_a.busy, 1'b1);
        chk1("rst_cmd_ready", bus_a.cmd_ready, 1'b0);
        chk1("rst_rd_valid", bus_a.rd_valid, 1'b0);
        chk4("rst_rd_data", bus_a.rd_data, 4'b0000);
        chk1("rst_addr_err", bus_a.addr_err, 1'b0);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("init_busy", bus_a.busy, 1'b1);
            chk1("init_cmd_ready", bus_a.cmd_ready, 1'b0);
        end
        tick();
        chk1("run_busy", bus_a.busy, 1'b0);
        chk1("run_cmd_ready", bus_a.cmd_ready, 1'b1);
        bus_a.mem_en = 1'b1;
        bus_a.rd_wr  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.addr = 2'(i);
            tick();
            chk1("init_rd_valid", bus_a.rd_valid, 1'b1);
            chk4("init_rd_data", bus_a.rd_data, 4'b0000);
        end
        bus_a.mem_en = 1'b0;
        tick();
        chk1("idle_rd_valid", bus_a.rd_valid, 1'b0);

        // 2: writes then back-to-back reads
        bus_a.mem_en = 1'b1;
        bus_a.rd_wr  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.addr    = 2'(i);
            bus_a.wr_data = wvals[i];
            tick();
            chk1("wr_no_valid", bus_a.rd_valid, 1'b0);
        end
        bus_a.rd_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.addr = rseq[i];
            tick();
            chk1("b2b_rd_valid", bus_a.rd_valid, 1'b1);
            chk4("b2b_rd_data", bus_a.rd_data, rexp[i]);
        end
        bus_a.mem_en = 1'b0;
        tick();
        chk1("b2b_drain", bus_a.rd_valid, 1'b0);

        // 3: backpressure stalls a pending write
        bus_a.mem_en = 1'b1;
        bus_a.rd_wr  = 1'b1;
        bus_a.addr   = 2'd1;
        tick();
        chk4("bp_first", bus_a.rd_data, 4'b0110);
        bus_a.rd_wr    = 1'b0;
        bus_a.wr_data  = 4'b0000;
        bus_a.rd_ready = 1'b0;
        #1;
        chk1("bp_cmd_ready0", bus_a.cmd_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("bp_hold_data", bus_a.rd_data, 4'b0110);
            chk1("bp_hold_valid", bus_a.rd_valid, 1'b1);
            chk1("bp_hold_ready", bus_a.cmd_ready, 1'b0);
        end
        bus_a.rd_ready = 1'b1;
        #1;
        chk1("bp_release_ready", bus_a.cmd_ready, 1'b1);
        tick();
        chk1("bp_consumed", bus_a.rd_valid, 1'b0);
        bus_a.rd_wr = 1'b1;
        tick();
        chk1("bp_reread_valid", bus_a.rd_valid, 1'b1);
        chk4("bp_reread_data", bus_a.rd_data, 4'b0000);

        // 4: reset mid-burst clears everything via the sweep
        bus_a.addr = 2'd3;
        tick();
        chk4("mid_pre_data", bus_a.rd_data, 4'b1111);
        bus_a.addr = 2'd0;
        rst_a = 1'b1;
        tick();
        chk1("mid_rst_valid", bus_a.rd_valid, 1'b0);
        chk1("mid_rst_busy", bus_a.busy, 1'b1);
        chk1("mid_rst_ready", bus_a.cmd_ready, 1'b0);
        chk4("mid_rst_data", bus_a.rd_data, 4'b0000);
        rst_a = 1'b0;
        bus_a.mem_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("mid_init_busy", bus_a.busy, 1'b1);
        end
        tick();
        chk1("mid_run_busy", bus_a.busy, 1'b0);
        bus_a.mem_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.addr = 2'(i);
            tick();
            chk1("mid_rd_valid", bus_a.rd_valid, 1'b1);
            chk4("mid_rd_cleared", bus_a.rd_data, 4'b0000);
        end
        bus_a.mem_en = 1'b0;
        tick();

        // 5: DEPTH=5 out-of-range handling
        rst_b = 1'b1;
        tick();
        chk1("b_rst_busy", bus_b.busy, 1'b1);
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("b_init_busy", bus_b.busy, 1'b1);
        end
        tick();
        chk1("b_run_busy", bus_b.busy, 1'b0);
        bus_b.mem_en  = 1'b1;
        bus_b.rd_wr   = 1'b0;
        bus_b.addr    = 3'd4;
        bus_b.wr_data = 4'b0111;
        tick();
        chk1("b_wr4_err", bus_b.addr_err, 1'b0);
        bus_b.addr    = 3'd5;
        bus_b.wr_data = 4'b1010;
        tick();
        chk1("b_wr5_err", bus_b.addr_err, 1'b1);
        chk1("b_wr5_valid", bus_b.rd_valid, 1'b0);
        bus_b.rd_wr = 1'b1;
        bus_b.addr  = 3'd4;
        tick();
        chk1("b_rd4_err", bus_b.addr_err, 1'b0);
        chk4("b_rd4_data", bus_b.rd_data, 4'b0111);
        bus_b.addr = 3'd5;
        tick();
        chk1("b_rd5_err", bus_b.addr_err, 1'b1);
        chk1("b_rd5_valid", bus_b.rd_valid, 1'b1);
        chk4("b_rd5_data", bus_b.rd_data, 4'b0000);
        bus_b.addr = 3'd1;
        tick();
        chk1("b_rd1_err", bus_b.addr_err, 1'b0);
        chk4("b_rd1_data", bus_b.rd_data, 4'b0000);
        bus_b.mem_en = 1'b0;
        tick();
        chk1("b_idle_err", bus_b.addr_err, 1'b0);
        chk1("b_idle_valid", bus_b.rd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_sync_ram

// File: doc/param_sync_ram.md
Name: param_sync_ram

Overview:
Parametrised, clocked, single-port RAM. It is the successor to the combinational/latched 4x4 RAM.
- Keeps the familiar mem_en / rd_wr / addr / wr_data / rd_data command style.
- Adds configurable width and depth.
- Runs a self-clearing initialisation sweep after reset.
- Adds a registered read response with valid/ready backpressure and out-of-range address detection.
- Serves as the generic storage element for register files and small buffers.

Parameters:
DATA_W, 4, data word width in bits.
DEPTH, 4, number of words; need not be a power of two (minimum 2).
ADDR_W, $clog2(DEPTH), address width.
INIT_VAL, {DATA_W{1'b0}}, value written to every word during the init sweep.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
mem_en  input  1  command valid.
rd_wr  input  1  1 = read, 0 = write.
addr  input  ADDR_W  word address.
wr_data  input  DATA_W  write data.
cmd_ready  output  1  command accepted on an edge where mem_en && cmd_ready.
rd_data  output  DATA_W  registered read data.
rd_valid  output  1  rd_data holds an unconsumed read response.
rd_ready  input  1  consumer accepts the response.
busy  output  1  init sweep in progress.
addr_err  output  1  one-cycle pulse: an accepted command had addr >= DEPTH.

Behaviour:
- Reset (sync, at an edge with rst=1):
  - state=ST_INIT, init_ptr=0.
  - rd_valid=0, rd_data=0, addr_err=0, busy=1.
  - cmd_ready=0.
  - Memory contents are not cleared by reset itself; they are cleared by the sweep.
- ST_INIT:
  - Each cycle: mem[init_ptr] <= INIT_VAL; init_ptr++.
  - On the edge writing init_ptr==DEPTH-1, next state is ST_RUN.
  - busy is high for exactly DEPTH cycles after reset deasserts.
  - Commands are ignored; cmd_ready=0.
- ST_RUN:
  - cmd_ready = !rd_valid || rd_ready (combinational).
  - This gives full throughput with back-to-back reads when rd_ready=1.
- Accepted write (rd_wr=0):
  - mem[addr] <= wr_data at that edge.
  - No response; rd_valid is not affected.
- Accepted read (rd_wr=1):
  - rd_data <= mem[addr] and rd_valid <= 1 at that edge.
  - Latency is 1 cycle.
- Response handshake:
  - If rd_valid && rd_ready and no new read is accepted, rd_valid <= 0 and rd_data holds its last value.
  - If rd_valid && !rd_ready, rd_data and rd_valid are frozen and cmd_ready=0, so all commands (including writes) stall.
  - If a read is accepted in the same cycle the old response is consumed, the new data replaces it and rd_valid stays 1.
- Write-then-read of the same address on consecutive accepted cycles returns the new data. A single port means no same-cycle collision.
- addr >= DEPTH (only possible when DEPTH is not a power of two):
  - Write: discarded.
  - Read: returns INIT_VAL with rd_valid=1.
  - Either case: addr_err=1 for the cycle after acceptance.
- Reset mid-operation (during RUN or during INIT):
  - Aborts everything and drops rd_valid.
  - Restarts the sweep from address 0, so all words return to INIT_VAL.
- Inputs are sampled only on accepting edges. wr_data, addr and rd_wr may change freely otherwise.

Decomposition:
- Shared package ram_pkg:
  - State enum ST_INIT/ST_RUN.
  - Op constants OP_WR=1'b0, OP_RD=1'b1.
- One sub-module, sync_ram_core:
  - Plain storage array: synchronous write port, synchronous read port.
  - Parametrised on DATA_W/DEPTH.
- param_sync_ram holds the FSM, init pointer, write mux (init versus user), handshake and error logic.

Test Plan:
1. Reset 1 cycle, then release.
   - busy=1 and cmd_ready=0 for 4 cycles, then busy=0 and cmd_ready=1.
   - Reading addr 0..3 returns 4'b0000.
2. Write 0001@0, 0110@1, 1110@2, 1111@3; then read 3,0,1,2 back-to-back with rd_ready=1.
   - rd_valid=1 on every cycle after the first read.
   - rd_data sequence: 1111, 0001, 0110, 1110.
3. Read addr 1 with rd_ready=0 for 3 cycles, while mem_en=1 presenting write 0000@1.
   - rd_data=0110 is held and cmd_ready=0 throughout.
   - Raise rd_ready: the write is accepted on that edge.
   - A subsequent read of addr 1 returns 0000.
4. After scenario 2, assert rst for 1 cycle mid-burst.
   - rd_valid drops on that edge.
   - busy is high for 4 cycles.
   - All four addresses then read 0000.
5. DEPTH=5, ADDR_W=3: write 1010@5, then read @5 and @4.
   - addr_err pulses after each access to address 5.
   - Read @5 returns 0000; address 4 is unaffected.
   - busy lasts 5 cycles after reset.
